// File: rtl/video_timing_pkg.sv
// Shared raster timing definitions: 720p defaults, derived totals and the
// pixel-coordinate types used by the sprite and compositing stages.
package video_timing_pkg;

  localparam int unsigned ACTIVE_H_DEF = 1280;
  localparam int unsigned H_FP_DEF     = 110;
  localparam int unsigned H_SYNC_DEF   = 40;
  localparam int unsigned H_BP_DEF     = 220;
  localparam int unsigned ACTIVE_V_DEF = 720;
  localparam int unsigned V_FP_DEF     = 5;
  localparam int unsigned V_SYNC_DEF   = 5;
  localparam int unsigned V_BP_DEF     = 20;
  localparam int unsigned FC_W_DEF     = 6;

  localparam int unsigned TOTAL_H = ACTIVE_H_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned TOTAL_V = ACTIVE_V_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

endpackage

// File: rtl/video_sig_gen_if.sv
// Bundle of raster timing signals as seen by downstream pipeline stages.
interface video_sig_gen_if
  import video_timing_pkg::*;
#(
  parameter int unsigned FC_W = FC_W_DEF
);
  hcount_t         hcount;
  vcount_t         vcount;
  logic            hs;
  logic            vs;
  logic            ad;
  logic            nf;
  logic [FC_W-1:0] fc;

  modport master (output hcount, vcount, hs, vs, ad, nf, fc);
  modport slave  (input  hcount, vcount, hs, vs, ad, nf, fc);
endinterface

// File: rtl/mod_counter.sv
// Modulo-MAX counter with enable; exposes its next value so the caller can
// register flags that line up with the count they describe.
module mod_counter #(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_next_c_o,
  output logic         wrap_c_o
);
  localparam logic [W:0]   ONE  = {{W{1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   sum_c;

  // Increment one bit wider so the carry never aliases into the wrap compare.
  assign sum_c    = {1'b0, count_q} + ONE;
  assign wrap_c_o = en_i && (count_q == LAST);

  // Next count: hold, step, or wrap to zero.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_c_o ? '0 : sum_c[W-1:0];
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o        = count_q;
  assign count_next_c_o = count_d;
endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel coordinates plus hsync, vsync, active-draw,
// new-frame strobe and frame counter, all registered with zero skew.
// Optional frame counter: define VIDEO_SIG_GEN_FC_EN; otherwise fc_out is 0.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H = ACTIVE_H_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned ACTIVE_V = ACTIVE_V_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned FC_W     = FC_W_DEF
) (
  input  logic            pixel_clk_in,
  input  logic            rst_in,
  output hcount_t         hcount_out,
  output vcount_t         vcount_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ad_out,
  output logic            nf_out,
  output logic [FC_W-1:0] fc_out
);
  localparam int unsigned TOT_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int unsigned TOT_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

  localparam hcount_t H_ACT    = hcount_t'(ACTIVE_H);
  localparam hcount_t HS_START = hcount_t'(ACTIVE_H + H_FP);
  localparam hcount_t HS_END   = hcount_t'(ACTIVE_H + H_FP + H_SYNC);
  localparam vcount_t V_ACT    = vcount_t'(ACTIVE_V);
  localparam vcount_t VS_START = vcount_t'(ACTIVE_V + V_FP);
  localparam vcount_t VS_END   = vcount_t'(ACTIVE_V + V_FP + V_SYNC);

  hcount_t h_q, h_d;
  vcount_t v_q, v_d;
  logic    h_wrap_c;
  logic    v_wrap_c;

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic ad_q, ad_d;
  logic nf_q, nf_d;

  mod_counter #(.MAX(TOT_H), .W(HCOUNT_W)) u_hcnt (
    .clk_i          (pixel_clk_in),
    .rst_i          (rst_in),
    .en_i           (1'b1),
    .count_o        (h_q),
    .count_next_c_o (h_d),
    .wrap_c_o       (h_wrap_c)
  );

  mod_counter #(.MAX(TOT_V), .W(VCOUNT_W)) u_vcnt (
    .clk_i          (pixel_clk_in),
    .rst_i          (rst_in),
    .en_i           (h_wrap_c),
    .count_o        (v_q),
    .count_next_c_o (v_d),
    .wrap_c_o       (v_wrap_c)
  );

  // Decode flags from the next coordinates so they land with the counts.
  always_comb begin
    hs_d = 1'b0;
    vs_d = 1'b0;
    ad_d = 1'b0;
    nf_d = 1'b0;
    hs_d = (h_d >= HS_START) && (h_d < HS_END);
    vs_d = (v_d >= VS_START) && (v_d < VS_END);
    ad_d = (h_d < H_ACT) && (v_d < V_ACT);
    nf_d = (h_d == H_ACT) && (v_d == V_ACT);
  end

  // Flag registers.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      ad_q <= 1'b0;
      nf_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      ad_q <= ad_d;
      nf_q <= nf_d;
    end
  end

`ifdef VIDEO_SIG_GEN_FC_EN
  localparam logic [FC_W-1:0] FC_ONE = FC_W'(1);
  logic [FC_W-1:0] fc_q, fc_d;

  // Frame count steps together with the new-frame strobe.
  always_comb begin
    fc_d = fc_q;
    if (nf_d) begin
      fc_d = fc_q + FC_ONE;
    end
  end

  // Frame counter register, wraps naturally at 2^FC_W.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign fc_out = fc_q;
`else
  assign fc_out = '0;
`endif

  assign hcount_out = h_q;
  assign vcount_out = v_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
endmodule

// File: tb/tb_video_sig_gen.sv
// Scoreboard bench for video_sig_gen on a shrunken raster (28x13 total,
// 16x6 active) so several frames and a 64-frame counter wrap fit quickly.
module tb_video_sig_gen;
  import video_timing_pkg::*;

  localparam int unsigned AH = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int unsigned AV = 6,  VFP = 2, VSW = 2, VBP = 3;
  localparam int unsigned FCW = 6;
  localparam int unsigned TH = AH + HFP + HSW + HBP;  // 28
  localparam int unsigned TV = AV + VFP + VSW + VBP;  // 13
  localparam int unsigned FRAME = TH * TV;            // 364

  typedef struct packed {
    hcount_t        h;
    vcount_t        v;
    logic           hs;
    logic           vs;
    logic           ad;
    logic           nf;
    logic [FCW-1:0] fc;
  } obs_t;

  typedef struct {
    int unsigned tag;
    obs_t        exp;
    bit          chk_fc;
    logic [79:0] name;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_sig_gen_if #(.FC_W(FCW)) vid ();

  video_sig_gen #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .FC_W(FCW)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .hcount_out   (vid.hcount),
    .vcount_out   (vid.vcount),
    .hs_out       (vid.hs),
    .vs_out       (vid.vs),
    .ad_out       (vid.ad),
    .nf_out       (vid.nf),
    .fc_out       (vid.fc)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned smp = 0;
  int unsigned issued = 0;
  int unsigned hs_cnt = 0, vs_cnt = 0, ad_cnt = 0, nf_cnt = 0;
  int unsigned last_nf = 0;
  item_t sb[$];

  // Hand-computed points relative to the last reset release: rel, h, v, hs, vs, ad, nf.
  localparam int NDIR = 17;
  int d_rel [NDIR] = '{1, 15, 16, 18, 19, 22, 23, 27, 28, 183, 184, 224, 251, 279, 280, 363, 364};
  int d_h   [NDIR] = '{1, 15, 16, 18, 19, 22, 23, 27,  0,  15,  16,   0,  27,  27,   0,  27,   0};
  int d_v   [NDIR] = '{0,  0,  0,  0,  0,  0,  0,  0,  1,   6,   6,   8,   8,   9,  10,  12,   0};
  bit d_hs  [NDIR] = '{0,  0,  0,  0,  1,  1,  0,  0,  0,   0,   0,   0,   0,   0,   0,   0,   0};
  bit d_vs  [NDIR] = '{0,  0,  0,  0,  0,  0,  0,  0,  0,   0,   0,   1,   1,   1,   0,   0,   0};
  bit d_ad  [NDIR] = '{1,  1,  0,  0,  0,  0,  0,  0,  1,   0,   0,   0,   0,   0,   0,   0,   1};
  bit d_nf  [NDIR] = '{0,  0,  0,  0,  0,  0,  0,  0,  0,   0,   1,   0,   0,   0,   0,   0,   0};

  // Reference model state (what the DUT should present after the next edge).
  int unsigned mh = 0, mv = 0, rel = 0;
  logic [FCW-1:0] mfc = '0;

  task automatic check(input logic [79:0] name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %0s smp=%0d act=%h exp=%h", name, smp, act, exp);
  endtask

  // One stimulus cycle: drive rst, push the model and any directed expectation.
  task automatic step(input logic r);
    item_t it;
    obs_t e;
    rst = r;
    if (r) begin
      mh = 0; mv = 0; mfc = '0; rel = 0;
      e = '0;
    end else begin
      rel++;
      mh++;
      if (mh == TH) begin
        mh = 0;
        mv++;
        if (mv == TV) mv = 0;
      end
      e.h  = hcount_t'(mh);
      e.v  = vcount_t'(mv);
      e.hs = (mh >= AH + HFP) && (mh < AH + HFP + HSW);
      e.vs = (mv >= AV + VFP) && (mv < AV + VFP + VSW);
      e.ad = (mh < AH) && (mv < AV);
      e.nf = (mh == AH) && (mv == AV);
`ifdef VIDEO_SIG_GEN_FC_EN
      if (e.nf) mfc = mfc + FCW'(1);
`endif
      e.fc = mfc;
    end
    issued++;
    it.tag = issued; it.exp = e; it.chk_fc = 1'b1; it.name = "model";
    sb.push_back(it);
    if (!r) begin
      for (int i = 0; i < NDIR; i++) begin
        if (d_rel[i] == int'(rel)) begin
          it.exp = '0;
          it.exp.h  = hcount_t'(d_h[i]);
          it.exp.v  = vcount_t'(d_v[i]);
          it.exp.hs = d_hs[i];
          it.exp.vs = d_vs[i];
          it.exp.ad = d_ad[i];
          it.exp.nf = d_nf[i];
          it.chk_fc = 1'b0;
          it.name   = "directed";
          sb.push_back(it);
        end
      end
    end
    @(negedge clk);
  endtask

  // Monitor: sample after each rising edge, pop and compare due expectations.
  always begin
    item_t it;
    obs_t act;
    @(posedge clk);
    #1;
    smp++;
    act = '{vid.hcount, vid.vcount, vid.hs, vid.vs, vid.ad, vid.nf, vid.fc};
    while (sb.size() > 0 && sb[0].tag <= smp) begin
      it = sb.pop_front();
      if (it.tag < smp) begin
        check("stale", 64'(it.tag), 64'(smp));
      end else if (it.chk_fc) begin
        check(it.name, 64'(act), 64'(it.exp));
      end else begin
        check(it.name, 64'({act.h, act.v, act.hs, act.vs, act.ad, act.nf}),
              64'({it.exp.h, it.exp.v, it.exp.hs, it.exp.vs, it.exp.ad, it.exp.nf}));
      end
    end
    hs_cnt += 32'(vid.hs);
    vs_cnt += 32'(vid.vs);
    ad_cnt += 32'(vid.ad);
    if (rst) begin
      last_nf = 0;
    end else if (vid.nf) begin
      nf_cnt++;
      if (last_nf != 0) check("nf_spacing", 64'(smp - last_nf), 64'(FRAME));
      last_nf = smp;
    end
  end

  initial begin
    logic [FCW-1:0] fc_exp;
    int unsigned guard;

    for (int i = 0; i < 5; i++) step(1'b1);

    // Three frames from release.
    hs_cnt = 0; vs_cnt = 0; ad_cnt = 0; nf_cnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0);
    check("hs_cycles", 64'(hs_cnt), 64'(156));
    check("vs_cycles", 64'(vs_cnt), 64'(168));
    check("ad_cycles", 64'(ad_cnt), 64'(288));
    check("nf_pulses", 64'(nf_cnt), 64'(3));
`ifdef VIDEO_SIG_GEN_FC_EN
    fc_exp = FCW'(3);
`else
    fc_exp = '0;
`endif
    check("fc_3frames", 64'(vid.fc), 64'(fc_exp));

    // One-cycle reset mid-frame at (10,4).
    guard = 0;
    while (!(mh == 10 && mv == 4) && guard < FRAME) begin
      step(1'b0);
      guard++;
    end
    check("reach_10_4", 64'(guard < FRAME), 64'(1));
    step(1'b1);
    check("rst_h", 64'(vid.hcount), 64'(0));
    check("rst_v", 64'(vid.vcount), 64'(0));

    // 63 then 64 frames after that reset: frame counter reaches 63 then wraps.
    nf_cnt = 0;
    for (int i = 0; i < 63 * FRAME; i++) step(1'b0);
`ifdef VIDEO_SIG_GEN_FC_EN
    fc_exp = FCW'(63);
`else
    fc_exp = '0;
`endif
    check("fc_63", 64'(vid.fc), 64'(fc_exp));
    for (int i = 0; i < FRAME; i++) step(1'b0);
    check("fc_wrap", 64'(vid.fc), 64'(0));
    check("nf_64", 64'(nf_cnt), 64'(64));

    @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
Raster timing generator for the HDMI video pipeline. It produces the hcount/vcount pixel coordinates that feed image_sprite and the other sprite/compositing stages. It also produces the matching hsync, vsync, active-draw, new-frame and frame-count signals, which pass through the same pipeline delay as the pixel data. Defaults give 1280x720@60 (74.25 MHz pixel clock).

Parameters:
ACTIVE_H, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, hsync pulse width (pixels)
H_BP, 220, horizontal back porch (pixels)
ACTIVE_V, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync pulse width (lines)
V_BP, 20, vertical back porch (lines)
FC_W, 6, frame counter width

Ports:
pixel_clk_in  input  1  pixel clock; single clock domain
rst_in  input  1  synchronous, active-high reset
hcount_out  output  11  horizontal position, 0..TOTAL_H-1
vcount_out  output  10  vertical position, 0..TOTAL_V-1
hs_out  output  1  hsync, active high
vs_out  output  1  vsync, active high
ad_out  output  1  active draw: hcount_out<ACTIVE_H and vcount_out<ACTIVE_V
nf_out  output  1  one-cycle new-frame strobe
fc_out  output  FC_W  frame counter

Behaviour:
- One clock: pixel_clk_in. Reset is synchronous and active-high on rst_in.
- Derived constants: TOTAL_H = ACTIVE_H+H_FP+H_SYNC+H_BP = 1650; TOTAL_V = ACTIVE_V+V_FP+V_SYNC+V_BP = 750.
- Reset value of every output is 0. Reset is sampled on the clock edge.
  - Reset asserted mid-frame: counters and outputs are 0 on the next edge.
  - First edge after rst_in deasserts: hcount_out advances 0->1, vcount_out stays 0.
- Counter stepping:
  - hcount_out increments by 1 every cycle.
  - At TOTAL_H-1 it wraps to 0, and on that same edge vcount_out increments.
  - vcount_out wraps TOTAL_V-1 -> 0 when hcount_out also wraps.
  - At hcount_out=1649, vcount_out=749, the next cycle is 0/0.
- All outputs are registered. hs/vs/ad/nf/fc describe the hcount_out/vcount_out value presented in the same cycle (zero skew between outputs).
- hs_out = 1 iff ACTIVE_H+H_FP <= hcount_out < ACTIVE_H+H_FP+H_SYNC, i.e. 1390..1429.
- vs_out = 1 iff ACTIVE_V+V_FP <= vcount_out < ACTIVE_V+V_FP+V_SYNC, i.e. 725..729 (whole lines).
- ad_out is 0 throughout blanking.
- nf_out = 1 for exactly one cycle per frame, when hcount_out==ACTIVE_H and vcount_out==ACTIVE_V (first blanking pixel after the last active line).
- fc_out increments in the same cycle nf_out is asserted. It wraps modulo 2^FC_W (63 -> 0).
- Width rule: comparisons are unsigned at counter width; the next-state adds are computed 1 bit wider before the wrap compare.
- No handshake: free-running. Downstream stages pipeline hs/vs/ad to match their own latency (image_sprite needs 4 stages).

Optional Feature:
- Macro: VIDEO_SIG_GEN_FC_EN.
- Defined: frame counter logic is present and fc_out behaves as specified above.
- Undefined: no frame-counter register; fc_out is constant 0. nf_out is unaffected.

Decomposition:
- Package video_timing_pkg holds:
  - localparams for the 720p timing (the parameter defaults);
  - TOTAL_H and TOTAL_V;
  - typedefs hcount_t = logic [10:0] and vcount_t = logic [9:0], shared with image_sprite and the compositor.
- One natural sub-module: mod_counter (parameter MAX, width; inputs clk, rst, en; outputs count and wrap strobe). It is instantiated twice: the horizontal counter's wrap strobe drives the vertical counter's enable.

Test Plan:
- Reset held 5 cycles, then released -> all outputs 0 during reset; next cycle hcount_out=1, vcount_out=0, ad_out=1.
- Run 1650 cycles -> hcount_out wraps 1649->0 and vcount_out goes 0->1 on the same edge; hs_out high for exactly 40 cycles, first at hcount_out=1390; ad_out low for hcount_out 1280..1649.
- Run a full frame (1650*750 = 1,237,500 cycles) -> vs_out high for exactly 5*1650 = 8250 cycles starting at vcount_out=725, hcount_out=0; vcount_out 749->0 at hcount_out wrap.
- Three frames -> nf_out pulses exactly 3 times, each at (1280,720), spaced 1,237,500 cycles apart; fc_out = 1, 2, 3 after each pulse (VIDEO_SIG_GEN_FC_EN defined).
- Preload frame count 63 via 64 frames -> fc_out wraps to 0; rebuild without macro -> fc_out stays 0 while nf_out still pulses.
- Assert rst_in for 1 cycle at hcount_out=700, vcount_out=400 -> next cycle all outputs 0; counting resumes from 0/0 with no nf_out glitch.
